// File: rtl/fault_latch_bank_if.sv
// fault_latch_bank_if: bundle of fault inputs, clear/lamp-test controls and latch status outputs
//   master: drives i_in (active-low faults), i_clear, i_la_test; observes o_* status
//   slave : the latch bank; consumes i_*, drives o_out, o_la, o_any_err, o_first_vld,
//           o_first_idx, o_err_cnt
interface fault_latch_bank_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]  i_in;
  logic [N_CH-1:0]  i_clear;
  logic             i_la_test;
  logic [N_CH-1:0]  o_out;
  logic [N_CH-1:0]  o_la;
  logic             o_any_err;
  logic             o_first_vld;
  logic [IDX_W-1:0] o_first_idx;
  logic [CNT_W-1:0] o_err_cnt;
  modport master(
    output i_in, i_clear, i_la_test,
    input  o_out, o_la, o_any_err, o_first_vld, o_first_idx, o_err_cnt
  );
  modport slave(
    input  i_in, i_clear, i_la_test,
    output o_out, o_la, o_any_err, o_first_vld, o_first_idx, o_err_cnt
  );
endinterface

// File: rtl/fault_latch_bank.sv
// fault_latch_bank: N_CH glitch-filtered fault latches with clear, first-fault capture, event counter and lamps
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-low reset
//   bus   : slave side of fault_latch_bank_if (faults/clears/lamp test in, flags/lamps/status out)
module fault_latch_bank #(
  parameter int N_CH             = 4,
  parameter int FILTER           = 3,
  parameter bit LA_ON_WHEN_RESET = 1'b0,
  parameter int CNT_W            = 8
) (
  input logic clk,
  input logic reset,
  fault_latch_bank_if.slave bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int FW    = $clog2(FILTER + 1);
  localparam int SW    = CNT_W + $clog2(N_CH + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [N_CH-1:0]  r_out;
  logic [FW-1:0]    r_fcnt [N_CH];
  logic             r_first_vld;
  logic [IDX_W-1:0] r_first_idx;
  logic [CNT_W-1:0] r_err_cnt;
  logic [N_CH-1:0]  w_latch;
  logic [N_CH-1:0]  w_nxt_out;
  logic [FW-1:0]    w_nxt_fcnt [N_CH];
  logic [IDX_W-1:0] w_low_idx;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_nxt_cnt;
  always_comb begin
    w_latch    = '0;
    w_nxt_out  = '0;
    w_nxt_fcnt = '{default: '0};
    w_low_idx  = '0;
    w_sum      = SW'(r_err_cnt);
    // descending scan so the lowest latching channel is the last one written
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_latch[i]    = ~r_out[i] & ~bus.i_in[i] & (r_fcnt[i] == FW'(FILTER - 1));
      w_nxt_out[i]  = r_out[i] ? ~(bus.i_clear[i] & bus.i_in[i]) : w_latch[i];
      w_nxt_fcnt[i] = (r_out[i] | w_latch[i] | bus.i_in[i] | bus.i_clear[i]) ? '0 : r_fcnt[i] + FW'(1);
      w_low_idx     = w_latch[i] ? IDX_W'(i) : w_low_idx;
      w_sum         = w_sum + SW'(w_latch[i]);
    end
    // a new latch starts a fresh episode when no previously latched channel survives this edge
    w_nxt_idx = ((|w_latch) & ~(|(r_out & w_nxt_out))) ? w_low_idx : r_first_idx;
    w_nxt_cnt = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out       <= '0;
      r_fcnt      <= '{default: '0};
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_out       <= w_nxt_out;
      r_fcnt      <= w_nxt_fcnt;
      r_first_vld <= |w_nxt_out;
      r_first_idx <= w_nxt_idx;
      r_err_cnt   <= w_nxt_cnt;
    end
  end
  assign bus.o_out       = r_out;
  assign bus.o_any_err   = |r_out;
  assign bus.o_la        = r_out | {N_CH{bus.i_la_test}} | {N_CH{LA_ON_WHEN_RESET & ~reset}};
  assign bus.o_first_vld = r_first_vld;
  assign bus.o_first_idx = r_first_idx;
  assign bus.o_err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_fault_latch_bank.sv
// tb_fault_latch_bank: directed vector table plus randomized run against a behavioural model
module tb_fault_latch_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n;
  logic [3:0] t_in, t_clr;
  logic       t_lt;
  fault_latch_bank_if #(.N_CH(4), .CNT_W(8)) if0 ();
  fault_latch_bank_if #(.N_CH(4), .CNT_W(8)) if1 ();
  fault_latch_bank_if #(.N_CH(4), .CNT_W(2)) if2 ();
  fault_latch_bank_if #(.N_CH(4), .CNT_W(8)) if3 ();
  assign if0.i_in = t_in; assign if0.i_clear = t_clr; assign if0.i_la_test = t_lt;
  assign if1.i_in = t_in; assign if1.i_clear = t_clr; assign if1.i_la_test = t_lt;
  assign if2.i_in = t_in; assign if2.i_clear = t_clr; assign if2.i_la_test = t_lt;
  assign if3.i_in = t_in; assign if3.i_clear = t_clr; assign if3.i_la_test = t_lt;
  fault_latch_bank #(.N_CH(4), .FILTER(3), .LA_ON_WHEN_RESET(1'b0), .CNT_W(8)) d0 (.clk(clk), .reset(rst_n), .bus(if0));
  fault_latch_bank #(.N_CH(4), .FILTER(3), .LA_ON_WHEN_RESET(1'b1), .CNT_W(8)) d1 (.clk(clk), .reset(rst_n), .bus(if1));
  fault_latch_bank #(.N_CH(4), .FILTER(3), .LA_ON_WHEN_RESET(1'b0), .CNT_W(2)) d2 (.clk(clk), .reset(rst_n), .bus(if2));
  fault_latch_bank #(.N_CH(4), .FILTER(1), .LA_ON_WHEN_RESET(1'b0), .CNT_W(8)) d3 (.clk(clk), .reset(rst_n), .bus(if3));
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  // model k=0: FILTER=3, k=1: FILTER=1; counts low runs, latched flags, episode first channel, total events
  int         m_low [2][4];
  logic [3:0] m_out [2];
  bit         m_fresh [2];
  int         m_fi [2];
  int         m_tot [2];
  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction
  task automatic model_edge();
    logic [3:0] nxt, nl;
    int flt;
    for (int k = 0; k < 2; k++) begin
      flt = (k == 0) ? 3 : 1;
      if (!rst_n) begin
        m_out[k] = '0; m_fresh[k] = 1'b1; m_fi[k] = 0; m_tot[k] = 0;
        for (int i = 0; i < 4; i++) m_low[k][i] = 0;
      end else begin
        nxt = m_out[k];
        nl  = '0;
        for (int i = 0; i < 4; i++) begin
          if (m_out[k][i]) begin
            if (t_clr[i] && t_in[i]) nxt[i] = 1'b0;
            m_low[k][i] = 0;
          end else if (!t_in[i] && m_low[k][i] + 1 >= flt) begin
            nxt[i] = 1'b1; nl[i] = 1'b1; m_low[k][i] = 0;
          end else begin
            m_low[k][i] = (t_in[i] || t_clr[i]) ? 0 : m_low[k][i] + 1;
          end
        end
        if ((m_out[k] & nxt) == 4'h0) m_fresh[k] = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (nl[i]) begin
            m_tot[k]++;
            if (m_fresh[k]) begin m_fi[k] = i; m_fresh[k] = 1'b0; end
          end
        end
        m_out[k] = nxt;
      end
    end
  endtask
  task automatic step(input logic r, input logic [3:0] i, input logic [3:0] c, input logic l);
    rst_n = r; t_in = i; t_clr = c; t_lt = l;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic check_f1();
    chk("f1_out", if3.o_out, m_out[1]);
    chk("f1_first_vld", if3.o_first_vld, int'(m_out[1] != 4'h0));
    chk("f1_first_idx", if3.o_first_idx, m_fi[1]);
    chk("f1_err_cnt", if3.o_err_cnt, sat(m_tot[1], 255));
  endtask
  task automatic check_model();
    logic [3:0] la;
    la = m_out[0] | (t_lt ? 4'hF : 4'h0);
    chk("out", if0.o_out, m_out[0]);
    chk("la", if0.o_la, la);
    chk("la_rst_on", if1.o_la, la | (rst_n ? 4'h0 : 4'hF));
    chk("any_err", if0.o_any_err, int'(m_out[0] != 4'h0));
    chk("first_vld", if0.o_first_vld, int'(m_out[0] != 4'h0));
    chk("first_idx", if0.o_first_idx, m_fi[0]);
    chk("err_cnt", if0.o_err_cnt, sat(m_tot[0], 255));
    chk("err_cnt_w2", if2.o_err_cnt, sat(m_tot[0], 3));
    check_f1();
  endtask
  typedef struct {
    logic       rst;
    logic [3:0] in;
    logic [3:0] clr;
    logic       lt;
    logic [3:0] out;
    logic       fv;
    int         fi;
    int         ec;
    logic [3:0] la;
  } vec_t;
  vec_t tbl [28];
  logic [3:0] flip, la_exp;
  initial begin
    tbl = '{
      '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hD, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hD, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hD, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hD, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hD, 4'h0, 1'b0, 4'h2, 1'b1, 1, 1, 4'h2},
      '{1'b1, 4'hD, 4'h2, 1'b0, 4'h2, 1'b1, 1, 1, 4'h2},
      '{1'b1, 4'hF, 4'h2, 1'b0, 4'h0, 1'b0, 1, 1, 4'h0},
      '{1'b1, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1, 1, 4'h0},
      '{1'b1, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1, 1, 4'h0},
      '{1'b1, 4'h3, 4'h0, 1'b0, 4'hC, 1'b1, 2, 3, 4'hC},
      '{1'b1, 4'h2, 4'h0, 1'b0, 4'hC, 1'b1, 2, 3, 4'hC},
      '{1'b1, 4'h2, 4'h0, 1'b0, 4'hC, 1'b1, 2, 3, 4'hC},
      '{1'b1, 4'h2, 4'h0, 1'b0, 4'hD, 1'b1, 2, 4, 4'hD},
      '{1'b1, 4'hF, 4'h0, 1'b1, 4'hD, 1'b1, 2, 4, 4'hF},
      '{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 2, 4, 4'h0},
      '{1'b1, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 2, 4, 4'h0},
      '{1'b1, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 2, 4, 4'h0},
      '{1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 4'h0},
      '{1'b1, 4'hE, 4'h0, 1'b0, 4'h1, 1'b1, 0, 1, 4'h1},
      '{1'b1, 4'hD, 4'h0, 1'b0, 4'h1, 1'b1, 0, 1, 4'h1},
      '{1'b1, 4'hD, 4'h0, 1'b0, 4'h1, 1'b1, 0, 1, 4'h1},
      '{1'b1, 4'hD, 4'h1, 1'b0, 4'h2, 1'b1, 1, 2, 4'h2}
    };
    for (int v = 0; v < 28; v++) begin
      step(tbl[v].rst, tbl[v].in, tbl[v].clr, tbl[v].lt);
      la_exp = tbl[v].la | (tbl[v].rst ? 4'h0 : 4'hF);
      chk($sformatf("v%0d_out", v), if0.o_out, tbl[v].out);
      chk($sformatf("v%0d_any_err", v), if0.o_any_err, int'(tbl[v].out != 4'h0));
      chk($sformatf("v%0d_first_vld", v), if0.o_first_vld, tbl[v].fv);
      chk($sformatf("v%0d_first_idx", v), if0.o_first_idx, tbl[v].fi);
      chk($sformatf("v%0d_err_cnt", v), if0.o_err_cnt, tbl[v].ec);
      chk($sformatf("v%0d_la", v), if0.o_la, tbl[v].la);
      chk($sformatf("v%0d_la_rst_on", v), if1.o_la, la_exp);
      chk($sformatf("v%0d_err_cnt_w2", v), if2.o_err_cnt, sat(tbl[v].ec, 3));
      check_f1();
    end
    // saturation on the 2-bit counter: repeated latch/clear on ch0 gives 1,2,3,3,3
    step(1'b0, 4'hF, 4'h0, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      step(1'b1, 4'hE, 4'h0, 1'b0);
      step(1'b1, 4'hE, 4'h0, 1'b0);
      step(1'b1, 4'hE, 4'h0, 1'b0);
      chk($sformatf("sat%0d_out", n), if2.o_out, 4'h1);
      chk($sformatf("sat%0d_cnt", n), if2.o_err_cnt, sat(n, 3));
      step(1'b1, 4'hF, 4'h1, 1'b0);
      chk($sformatf("sat%0d_clr", n), if2.o_out, 4'h0);
    end
    t_in = 4'hF;
    for (int c = 0; c < 600; c++) begin
      flip = '0;
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(0, 9) < 3);
      step($urandom_range(0, 59) != 0, t_in ^ flip, 4'($urandom) & 4'($urandom), $urandom_range(0, 9) == 0);
      check_model();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
